// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes, burst FSM states
// and the data-path next-value function (also used by the bench reference model).
package usr_pkg;

    // Widest register the shared next-value function supports.
    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = $clog2(MAX_W);
    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } burst_state_e;

    // Next register value for a 'width'-bit register held in the low bits of a MAX_W vector.
    function automatic logic [MAX_W-1:0] next_value(
        input logic [MAX_W-1:0]  q,
        input logic [MODE_W-1:0] mode,
        input logic              right_in,
        input logic              left_in,
        input logic [MAX_W-1:0]  data_in,
        input int unsigned       width
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] qm;
        logic [MAX_W-1:0] top_bit;
        logic [MAX_W-1:0] r;
        logic             msb;
        mask    = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        qm      = q & mask;
        msb     = qm[IDX_W'(width - 1)];
        top_bit = MAX_W'(1) << (width - 1);
        case (mode)
            MODE_HOLD: r = qm;
            MODE_SHR:  r = (qm >> 1) | (right_in ? top_bit : '0);
            MODE_SHL:  r = ((qm << 1) | MAX_W'(left_in)) & mask;
            MODE_LOAD: r = data_in & mask;
            MODE_ROR:  r = (qm >> 1) | (qm[0] ? top_bit : '0);
            MODE_ROL:  r = ((qm << 1) | MAX_W'(msb)) & mask;
            MODE_ASR:  r = (qm >> 1) | (msb ? top_bit : '0);
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: accepts a counted burst, replays the latched mode N times,
// and steers the data path between direct (live) and burst (latched) operation.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [CNT_W-1:0]  shift_cnt,
    output logic              busy,
    output logic              done,
    output logic              apply_c,
    output logic [MODE_W-1:0] op_mode_c
);

    burst_state_e      state_q;
    burst_state_e      state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [MODE_W-1:0] lmode_q;
    logic [MODE_W-1:0] lmode_d;
    logic              busy_d;
    logic              done_d;

    // State, count, latched mode and registered flags; everything frozen while en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lmode_q <= MODE_HOLD;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lmode_q <= lmode_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next state: latch on start when idle, count down while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lmode_d = lmode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lmode_d = mode;
                    cnt_d   = shift_cnt;
                    if (shift_cnt != '0) begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: next busy/done, and which op (if any) the data path applies at this edge.
    always_comb begin
        busy_d    = (state_d == ST_BUSY);
        done_d    = 1'b0;
        apply_c   = 1'b0;
        op_mode_c = mode;
        if (state_q == ST_BUSY) begin
            apply_c   = 1'b1;
            op_mode_c = lmode_q;
            done_d    = (cnt_q == CNT_W'(1));
        end else begin
            // start wins over the direct op; a zero-length burst completes immediately
            apply_c = !start;
            done_d  = start && (shift_cnt == '0);
        end
    end

endmodule

// File: rtl/param_universal_shift_register.sv
// Parametrised universal shift register with serial taps and a counted burst engine.
module param_universal_shift_register
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic              right_in,
    input  logic              left_in,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              start,
    input  logic [CNT_W-1:0]  shift_cnt,
    output logic [WIDTH-1:0]  data_out,
    output logic              right_out,
    output logic              left_out,
    output logic              busy,
    output logic              done
);

    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  next_q;
    logic              apply_c;
    logic [MODE_W-1:0] op_mode_c;

    usr_burst_ctrl #(
        .CNT_W (CNT_W)
    ) u_burst_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .mode      (mode),
        .shift_cnt (shift_cnt),
        .busy      (busy),
        .done      (done),
        .apply_c   (apply_c),
        .op_mode_c (op_mode_c)
    );

    // Candidate register value for the selected (live or latched) operation.
    always_comb begin
        next_q = WIDTH'(next_value(MAX_W'(q), op_mode_c, right_in, left_in,
                                   MAX_W'(data_in), WIDTH));
    end

    // Data register; updates only on enabled edges where an op is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && apply_c) begin
            q <= next_q;
        end
    end

    assign data_out  = q;
    assign right_out = q[0];
    assign left_out  = q[WIDTH-1];

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed and randomised checks for param_universal_shift_register (WIDTH=8, CNT_W=4).
module tb_param_universal_shift_register;
    import usr_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [2:0]       mode;
    logic             right_in;
    logic             left_in;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic [CNT_W-1:0] shift_cnt;
    logic [WIDTH-1:0] data_out;
    logic             right_out;
    logic             left_out;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;

    // reference model state
    logic [WIDTH-1:0] m_q;
    logic             m_busy;
    logic             m_done;
    logic [CNT_W-1:0] m_cnt;
    logic [2:0]       m_mode;
    int               accepted;
    int               dut_dones;

    param_universal_shift_register #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .right_in  (right_in),
        .left_in   (left_in),
        .data_in   (data_in),
        .start     (start),
        .shift_cnt (shift_cnt),
        .data_out  (data_out),
        .right_out (right_out),
        .left_out  (left_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_taps(input string tag, input logic [WIDTH-1:0] exp);
        check({tag, "_data"}, 64'(data_out), 64'(exp));
        check({tag, "_rout"}, 64'(right_out), 64'(exp[0]));
        check({tag, "_lout"}, 64'(left_out), 64'(exp[WIDTH-1]));
    endtask

    // reference behaviour for one clock edge with the current inputs
    task automatic model_step();
        if (en) begin
            if (m_busy) begin
                m_q    = WIDTH'(next_value(64'(m_q), m_mode, right_in, left_in, 64'(data_in), WIDTH));
                m_done = (m_cnt == 4'd1);
                m_cnt  = m_cnt - 4'd1;
                m_busy = (m_cnt != 4'd0);
            end else if (start) begin
                m_mode = mode;
                m_cnt  = shift_cnt;
                m_busy = (shift_cnt != 4'd0);
                m_done = (shift_cnt == 4'd0);
                accepted++;
            end else begin
                m_q    = WIDTH'(next_value(64'(m_q), mode, right_in, left_in, 64'(data_in), WIDTH));
                m_done = 1'b0;
            end
        end
    endtask

    initial begin
        int late_dones;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; right_in = 1'b0; left_in = 1'b0;
        data_in = '0; start = 1'b0; shift_cnt = '0;

        // reset state
        #2;
        check("rst_data", 64'(data_out), 64'h00);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        step(); step();
        rst_n = 1'b1;

        // load, hold, enable gating
        en = 1'b1; mode = MODE_LOAD; data_in = 8'hA5; step();
        check("load_a5", 64'(data_out), 64'hA5);
        mode = MODE_HOLD;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold", 64'(data_out), 64'hA5);
        end
        en = 1'b0; mode = MODE_LOAD; data_in = 8'hFF; step();
        check("en_low", 64'(data_out), 64'hA5);

        // direct shifts
        en = 1'b1; data_in = 8'h81; step();           check_taps("load81", 8'h81);
        mode = MODE_SHR; right_in = 1'b0; step();     check_taps("shr", 8'h40);
        mode = MODE_SHL; left_in = 1'b1; step();      check_taps("shl", 8'h81);
        mode = MODE_ROR; step();                      check_taps("ror", 8'hC0);
        mode = MODE_ROL; step();                      check_taps("rol", 8'h81);
        mode = MODE_LOAD; data_in = 8'h80; step();    check_taps("load80", 8'h80);
        mode = MODE_ASR; right_in = 1'b0; step();     check_taps("asr1", 8'hC0);
        step();                                       check_taps("asr2", 8'hE0);

        // ROL burst of 3 from 0x01, live mode switched to CLR
        mode = MODE_LOAD; data_in = 8'h01; step();
        start = 1'b1; mode = MODE_ROL; shift_cnt = 4'd3; step();
        check("b_acc_data", 64'(data_out), 64'h01);
        check("b_acc_busy", 64'(busy), 64'h1);
        start = 1'b0; mode = MODE_CLR;
        step(); check("b1_data", 64'(data_out), 64'h02); check("b1_busy", 64'(busy), 64'h1);
        check("b1_done", 64'(done), 64'h0);
        step(); check("b2_data", 64'(data_out), 64'h04); check("b2_busy", 64'(busy), 64'h1);
        step(); check("b3_data", 64'(data_out), 64'h08); check("b3_busy", 64'(busy), 64'h0);
        check("b3_done", 64'(done), 64'h1);
        mode = MODE_HOLD; step();
        check("b_after_done", 64'(done), 64'h0);
        check("b_after_data", 64'(data_out), 64'h08);

        // zero-length burst
        start = 1'b1; mode = MODE_SHL; shift_cnt = 4'd0; step();
        check("z_data", 64'(data_out), 64'h08);
        check("z_busy", 64'(busy), 64'h0);
        check("z_done", 64'(done), 64'h1);
        start = 1'b0; mode = MODE_HOLD; step();
        check("z_done_clr", 64'(done), 64'h0);

        // start while busy is ignored
        start = 1'b1; mode = MODE_ROL; shift_cnt = 4'd2; step();
        shift_cnt = 4'd5; mode = MODE_CLR; step();
        check("sb1_data", 64'(data_out), 64'h10);
        start = 1'b0; mode = MODE_HOLD; step();
        check("sb2_data", 64'(data_out), 64'h20);
        check("sb2_done", 64'(done), 64'h1);
        step();
        check("sb3_data", 64'(data_out), 64'h20);
        check("sb3_busy", 64'(busy), 64'h0);

        // en low mid-burst stretches it; done holds while en=0
        start = 1'b1; mode = MODE_SHR; right_in = 1'b1; shift_cnt = 4'd3; step();
        start = 1'b0; mode = MODE_HOLD; step();
        check("st1_data", 64'(data_out), 64'h90);
        en = 1'b0; step(); step();
        check("st_hold_data", 64'(data_out), 64'h90);
        check("st_hold_busy", 64'(busy), 64'h1);
        en = 1'b1; step();
        check("st2_data", 64'(data_out), 64'hC8);
        step();
        check("st3_data", 64'(data_out), 64'hE4);
        check("st3_done", 64'(done), 64'h1);
        en = 1'b0; step();
        check("done_held", 64'(done), 64'h1);
        en = 1'b1; step();
        check("done_clr", 64'(done), 64'h0);

        // asynchronous reset mid-burst
        right_in = 1'b0; mode = MODE_LOAD; data_in = 8'h0F; step();
        start = 1'b1; mode = MODE_ROR; shift_cnt = 4'd10; step();
        start = 1'b0; mode = MODE_HOLD;
        step(); step(); step(); step();
        check("rb_pre_data", 64'(data_out), 64'hF0);
        check("rb_pre_busy", 64'(busy), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rb_data", 64'(data_out), 64'h00);
        check("rb_busy", 64'(busy), 64'h0);
        check("rb_done", 64'(done), 64'h0);
        step();
        rst_n = 1'b1;
        late_dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) late_dones++;
        end
        check("rb_no_done", 64'(late_dones), 64'h0);
        check("rb_post_data", 64'(data_out), 64'h00);

        // randomised soak against the reference model
        m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_cnt = '0; m_mode = MODE_HOLD;
        accepted = 0; dut_dones = 0;
        for (int i = 0; i < 1000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            start     = ($urandom_range(0, 5) == 0);
            mode      = 3'($urandom_range(0, 7));
            shift_cnt = 4'($urandom_range(0, 5));
            right_in  = 1'($urandom_range(0, 1));
            left_in   = 1'($urandom_range(0, 1));
            data_in   = 8'($urandom_range(0, 255));
            model_step();
            step();
            if (en && done) dut_dones++;
            check("soak_data", 64'(data_out), 64'(m_q));
            check("soak_busy", 64'(busy), 64'(m_busy));
            check("soak_done", 64'(done), 64'(m_done));
        end
        // drain any burst still in flight
        en = 1'b1; start = 1'b0; mode = MODE_HOLD;
        for (int i = 0; i < 20; i++) begin
            model_step();
            step();
            if (done) dut_dones++;
        end
        check("soak_data_end", 64'(data_out), 64'(m_q));
        check("soak_dones", 64'(dut_dones), 64'(accepted));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_universal_shift_register.md
Name: param_universal_shift_register

Overview:
Parametrised successor to the 4-bit bidirectional shift register. Generalises width and adds rotate, arithmetic-shift and clear modes. Adds a counted burst engine that applies one latched operation N times and then signals completion. Serves as the shared shift/serialiser resource for the experiment datapaths, with serial taps on both ends.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst count; max burst = 2**CNT_W-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable for all register/counter updates except reset
mode  input  3  operation select (encoding below)
right_in  input  1  serial input entering at MSB on shift right
left_in  input  1  serial input entering at LSB on shift left
data_in  input  WIDTH  parallel load data
start  input  1  burst request, sampled when en=1
shift_cnt  input  CNT_W  burst length, sampled with start
data_out  output  WIDTH  register contents
right_out  output  1  data_out[0], combinational from register
left_out  output  1  data_out[WIDTH-1], combinational from register
busy  output  1  burst in progress
done  output  1  one-cycle burst-complete pulse

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: data_out=0, busy=0, done=0, internal count=0, latched mode=HOLD. Reset asserted mid-burst aborts the burst immediately; no done pulse is issued.
- Mode encoding:
  - 000 HOLD
  - 001 SHR: {right_in, q[W-1:1]}
  - 010 SHL: {q[W-2:0], left_in}
  - 011 LOAD: data_in
  - 100 ROR: {q[0], q[W-1:1]}
  - 101 ROL: {q[W-2:0], q[W-1]}
  - 110 ASR: {q[W-1], q[W-1:1]}; right_in ignored
  - 111 CLR: all zeros
- Register update rule: all updates happen at the rising edge with en=1. With en=0, nothing changes (including done, which holds its value).
- Direct operation: busy=0 and start=0 → the mode op is applied at the edge. This is one op per enabled cycle, with zero latency to data_out after the edge.
- Burst acceptance: busy=0, start=1 at an enabled edge:
  - mode and shift_cnt are latched.
  - No data op is performed at the acceptance edge; start has priority over the direct op.
  - shift_cnt>0 → busy=1, count=shift_cnt.
  - shift_cnt=0 → busy stays 0, done=1 for the following cycle, data unchanged.
- Burst execution: each enabled edge while busy=1:
  - Applies the latched mode and decrements count.
  - Live mode, data_in and start are ignored, except that serial inputs are sampled live each cycle.
  - The edge where count goes 1→0 clears busy and sets done=1.
  - N shifts therefore finish N enabled edges after acceptance.
- done timing: done is high for exactly one enabled cycle, then clears at the next enabled edge unless a new zero-length burst is accepted there.
- start while busy=1: ignored, no queuing.
- Back-to-back bursts: start at the edge where done is asserted is accepted, since busy=0 in that cycle's inputs.
- LOAD/CLR/HOLD in burst mode: legal; the op is repeated N times, and done still pulses.
- Width rules: WIDTH=2 must work for all modes. CNT_W sets the maximum burst length; no overflow is possible.

Decomposition:
- Package usr_pkg: localparams MODE_HOLD..MODE_CLR (3-bit) and a function next_value(q, mode, right_in, left_in, data_in) shared with the bench's reference model.
- One sub-module, usr_burst_ctrl: the IDLE/BUSY FSM with count, latched mode, busy and done. The top holds the data register and muxes direct mode vs latched mode into next_value.

Test Plan (WIDTH=8, CNT_W=4):
- Reset / load / hold: reset → data_out=0x00, busy=0, done=0; then LOAD data_in=0xA5, en=1 → 0xA5; HOLD for 3 cycles → 0xA5; en=0 with LOAD 0xFF → still 0xA5.
- Direct shifts: from 0x81, SHR with right_in=0 → 0x40; SHL with left_in=1 → 0x81; ROR → 0xC0; ROL → 0x81; ASR from 0x80 → 0xC0 → 0xE0. Check right_out/left_out each cycle.
- Burst: from 0x01, start with mode=ROL, shift_cnt=3 → busy=1 for 3 enabled cycles, data 0x02, 0x04, 0x08. done=1 for one cycle after the third shift. Live mode changes to CLR during the burst have no effect.
- Burst boundaries:
  - shift_cnt=0 → done pulses next cycle, data unchanged, busy never set.
  - start during busy → ignored; total shifts equals the first count.
  - en low for 2 cycles mid-burst → burst stretches by 2 cycles, same final value.
- Reset mid-burst: start ROR cnt=10 on 0x0F, assert rst_n=0 asynchronously after 4 shifts → data_out=0x00, busy=0 immediately with no clock edge, and no done after release.
- Randomised soak: 1000 cycles of random mode/en/start/serial inputs compared against a usr_pkg::next_value model. Verify zero mismatches and done count equal to the number of accepted bursts.
